// File: rtl/mem_burst_responder.sv
// Byte-wide RAM responder: streams addr..addr+extra into a little-endian data word,
// one byte per cycle, with a bounds check decided at accept time and a host byte-write port.
module mem_burst_responder #(
    parameter int    AW      = 6,
    parameter int    DW      = 8,
    parameter int    EXTRA   = 4,
    parameter string ROMFILE = ""
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic [AW:0]              addr,
    input  logic [EXTRA-1:0]         extra,
    input  logic [AW:0]              lower_bound,
    input  logic [AW:0]              upper_bound,
    output logic [(2**EXTRA)*8-1:0]  data,
    output logic                     error,
    output logic                     valid,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready
);
    localparam int DEPTH = 2**AW;
    localparam int NB    = 2**EXTRA;

    if (DW != 8) begin : g_dw_check
        $error("mem_burst_responder: DW must be 8");
    end

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                 state, state_d;
    logic [AW-1:0]          addr_q;
    logic [EXTRA-1:0]       extra_q;
    logic [EXTRA-1:0]       k_q;
    logic [NB-1:0][7:0]     data_q;
    logic                   error_q;
    logic [DW-1:0]          mem [DEPTH];

    logic                   accept;
    logic [AW+1:0]          end_addr;
    logic                   bounds_err;
    logic [AW-1:0]          rd_idx;
    logic [7:0]             rd_byte;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    assign accept = (state == IDLE) && req;

    // One extra bit of headroom so addr+extra never wraps before the compare.
    assign end_addr   = {1'b0, addr} + (AW+2)'(extra);
    assign bounds_err = ({1'b0, addr} < {1'b0, lower_bound}) ||
                        (end_addr > {1'b0, upper_bound}) ||
                        (end_addr > (AW+2)'(DEPTH-1));

    assign rd_idx  = addr_q + AW'(k_q);
    assign rd_byte = mem[rd_idx];

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req) state_d = bounds_err ? DONE : FETCH;
            FETCH:   if (k_q == extra_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            extra_q <= '0;
            k_q     <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else if (accept) begin
            // Out-of-range requests never read memory, so only the low bits matter.
            addr_q  <= addr[AW-1:0];
            extra_q <= extra;
            k_q     <= '0;
            data_q  <= '0;
            error_q <= bounds_err;
        end else if (state == FETCH) begin
            data_q[k_q] <= rd_byte;
            k_q         <= k_q + 1'b1;
        end
    end

    // Writes are only taken when no read is active or arriving, so reads never race them.
    always @(posedge clk) begin
        if (wr_en && wr_ready) mem[wr_addr] <= wr_data;
    end

    assign data     = data_q;
    assign error    = error_q;
    assign valid    = (state == DONE);
    assign busy     = (state != IDLE);
    assign wr_ready = !busy && !req;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Randomized bench for mem_burst_responder against a byte-array reference model.
module tb_mem_burst_responder;
    logic         clk;
    logic         reset;
    logic         req;
    logic [6:0]   addr;
    logic [3:0]   extra;
    logic [6:0]   lower_bound;
    logic [6:0]   upper_bound;
    logic [127:0] data;
    logic         error;
    logic         valid;
    logic         busy;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         wr_ready;

    logic [7:0]   model_mem [64];
    int           n_chk;
    int           n_fail;

    mem_burst_responder dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .extra(extra),
        .lower_bound(lower_bound), .upper_bound(upper_bound),
        .data(data), .error(error), .valid(valid), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        req     = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = 8'(d);
        #1;
        chk("wr_ready_idle", 128'(wr_ready), 128'(1));
        step();
        wr_en = 1'b0;
        model_mem[a] = 8'(d);
    endtask

    // Issues one read from IDLE and checks latency, payload, error and pulse shape.
    // While busy, request and write inputs are driven with garbage that must be ignored.
    task automatic do_read(input int a, input int e, input int lo, input int hi,
                           input bit collide, input int wa, input int wd);
        logic [127:0] exp_d;
        bit           exp_e;
        int           exp_lat;
        int           lat;
        exp_e = (a < lo) || (a + e > hi) || (a + e > 63);
        exp_d = '0;
        if (!exp_e)
            for (int k = 0; k <= e; k++) exp_d[8*k +: 8] = model_mem[a+k];
        exp_lat = exp_e ? 1 : e + 2;

        req = 1'b1; addr = 7'(a); extra = 4'(e);
        lower_bound = 7'(lo); upper_bound = 7'(hi);
        wr_en = collide; wr_addr = 6'(wa); wr_data = 8'(wd);
        #1;
        chk("wr_ready_req", 128'(wr_ready), 128'(0));
        step();
        lat = 1;
        while (!valid && lat < 40) begin
            req = 1'($urandom); addr = 7'($urandom); extra = 4'($urandom);
            wr_en = 1'($urandom); wr_addr = 6'($urandom); wr_data = 8'($urandom);
            step();
            lat++;
        end
        req = 1'b0;
        wr_en = 1'b0;
        chk("latency", 128'(lat), 128'(exp_lat));
        chk("data", data, exp_d);
        chk("error", 128'(error), 128'(exp_e));
        chk("busy_at_valid", 128'(busy), 128'(1));
        step();
        chk("valid_one_cycle", 128'(valid), 128'(0));
        chk("data_hold", data, exp_d);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
        reset = 1'b1; req = 1'b0; addr = '0; extra = '0;
        lower_bound = '0; upper_bound = 7'd127;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data, 128'(0));
        chk("rst_error", 128'(error), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_wr_ready", 128'(wr_ready), 128'(1));
        reset = 1'b0;
        step();

        // Single non-zero byte followed by zeros.
        do_write(5, 8'h2A);
        for (int i = 6; i <= 12; i++) do_write(i, 0);
        do_read(5, 7, 0, 127, 0, 0, 0);

        // Full-width read.
        for (int i = 0; i < 16; i++) do_write(i, 8'h10 + i);
        do_read(0, 15, 0, 127, 0, 0, 0);
        do_read(7, 0, 0, 127, 0, 0, 0);

        // Bounds violations and edges.
        do_read(3, 1, 4, 127, 0, 0, 0);
        do_read(62, 3, 0, 127, 0, 0, 0);
        do_read(64, 0, 0, 127, 0, 0, 0);
        do_read(10, 5, 0, 14, 0, 0, 0);
        do_read(10, 4, 10, 14, 0, 0, 0);
        do_read(48, 15, 0, 63, 0, 0, 0);

        // Read wins over a simultaneous write; retry succeeds.
        do_write(20, 8'h55);
        do_read(20, 0, 0, 127, 1, 20, 8'h77);
        do_read(20, 0, 0, 127, 0, 0, 0);
        do_write(20, 8'h77);
        do_read(20, 0, 0, 127, 0, 0, 0);

        // Reset two cycles into a long read aborts it silently.
        req = 1'b1; addr = 7'd0; extra = 4'd7; lower_bound = 7'd0; upper_bound = 7'd127;
        step();
        req = 1'b0;
        chk("abort_busy", 128'(busy), 128'(1));
        chk("abort_valid0", 128'(valid), 128'(0));
        step();
        chk("abort_valid1", 128'(valid), 128'(0));
        reset = 1'b1;
        step();
        chk("abort_valid_rst", 128'(valid), 128'(0));
        chk("abort_busy_rst", 128'(busy), 128'(0));
        chk("abort_data_rst", data, 128'(0));
        reset = 1'b0;
        step();
        chk("abort_valid_after", 128'(valid), 128'(0));
        do_read(0, 7, 0, 127, 0, 0, 0);

        // req held high with extra=0: one result every 3 cycles, one idle cycle between.
        do_write(30, 8'hC3);
        req = 1'b1; addr = 7'd30; extra = 4'd0; lower_bound = 7'd0; upper_bound = 7'd127;
        step();
        for (int c = 1; c <= 11; c++) begin
            chk("b2b_valid", 128'(valid), 128'(c % 3 == 2));
            chk("b2b_busy", 128'(busy), 128'(c % 3 != 0));
            if (c % 3 == 2) chk("b2b_data", data, 128'(8'hC3));
            if (c == 11) req = 1'b0;
            step();
        end
        chk("b2b_idle", 128'(busy), 128'(0));

        // Random traffic.
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++)
                do_write(int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
            do_read(int'($urandom_range(0, 70)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 20)), int'($urandom_range(30, 127)), 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
